// File: rtl/mem_bus_initiator.sv
// Native memory bus initiator: queues read/write commands, issues them one at a
// time with a response timeout, and returns read data / error on a response port.
module mem_bus_initiator #(
   parameter int unsigned CMD_DEPTH = 4,
   parameter int unsigned TIMEOUT   = 16,
   parameter logic [31:0] ERR_RDATA = 32'hDEAD_BEEF
) (
   input  logic        clk,
   input  logic        rst_n,
   input  logic        cmd_valid,
   output logic        cmd_ready,
   input  logic [31:0] cmd_addr,
   input  logic [31:0] cmd_wdata,
   input  logic [3:0]  cmd_wstrb,
   output logic        rsp_valid,
   input  logic        rsp_ready,
   output logic [31:0] rsp_rdata,
   output logic        rsp_err,
   output logic        mem_valid,
   output logic [31:0] mem_addr,
   output logic [31:0] mem_wdata,
   output logic [3:0]  mem_wstrb,
   input  logic [31:0] mem_rdata,
   input  logic        mem_ready,
   output logic        busy
);

   localparam int unsigned ADDR_W = 32;
   localparam int unsigned DATA_W = 32;
   localparam int unsigned STRB_W = 4;
   localparam int unsigned PTR_W  = (CMD_DEPTH > 1) ? $clog2(CMD_DEPTH) : 1;
   localparam int unsigned CNT_W  = $clog2(CMD_DEPTH + 1);
   localparam int unsigned TMO_W  = $clog2(TIMEOUT + 1);

   typedef enum logic [1:0] {S_IDLE, S_REQ, S_WAIT, S_RESP} state_t;

   state_t state_q, state_d;

   logic [ADDR_W-1:0] fifo_addr  [CMD_DEPTH];
   logic [DATA_W-1:0] fifo_wdata [CMD_DEPTH];
   logic [STRB_W-1:0] fifo_wstrb [CMD_DEPTH];
   logic [PTR_W-1:0]  wr_ptr_q, rd_ptr_q;
   logic [CNT_W-1:0]  count_q, count_d;
   logic              full, empty, push, pop;

   logic [TMO_W-1:0]  tmo_q, tmo_d;
   logic              mem_valid_d, rsp_valid_d, rsp_err_d, busy_d;
   logic [ADDR_W-1:0] mem_addr_d;
   logic [DATA_W-1:0] mem_wdata_d, rsp_rdata_d;
   logic [STRB_W-1:0] mem_wstrb_d;
   logic              is_read;

   assign full      = (count_q == CNT_W'(CMD_DEPTH));
   assign empty     = (count_q == '0);
   assign cmd_ready = !full;
   assign push      = cmd_valid && !full;
   assign pop       = (state_q == S_IDLE) && !empty;
   assign is_read   = (mem_wstrb == '0);

   always_comb begin
      count_d = count_q;
      case ({push, pop})
         2'b10:   count_d = count_q + CNT_W'(1);
         2'b01:   count_d = count_q - CNT_W'(1);
         default: count_d = count_q;
      endcase
   end

   // Command storage; contents are don't-care until written, so no reset
   always_ff @(posedge clk) begin
      if (push) begin
         fifo_addr[wr_ptr_q]  <= cmd_addr;
         fifo_wdata[wr_ptr_q] <= cmd_wdata;
         fifo_wstrb[wr_ptr_q] <= cmd_wstrb;
      end
   end

   always_ff @(posedge clk) begin
      if (!rst_n) begin
         wr_ptr_q <= '0;
         rd_ptr_q <= '0;
         count_q  <= '0;
      end else begin
         if (push) wr_ptr_q <= wr_ptr_q + PTR_W'(1);
         if (pop)  rd_ptr_q <= rd_ptr_q + PTR_W'(1);
         count_q <= count_d;
      end
   end

   always_ff @(posedge clk) begin
      if (!rst_n) state_q <= S_IDLE;
      else        state_q <= state_d;
   end

   always_comb begin
      state_d = state_q;
      case (state_q)
         S_IDLE:  if (!empty) state_d = S_REQ;
         S_REQ:   state_d = S_WAIT;
         S_WAIT:  if (mem_ready || (tmo_q == TMO_W'(TIMEOUT))) state_d = S_RESP;
         S_RESP:  if (rsp_ready) state_d = S_IDLE;
         default: state_d = S_IDLE;
      endcase
   end

   // REQ ignores mem_ready: a responder may still show ready from the previous access
   always_comb begin
      mem_valid_d = mem_valid;
      mem_addr_d  = mem_addr;
      mem_wdata_d = mem_wdata;
      mem_wstrb_d = mem_wstrb;
      rsp_valid_d = rsp_valid;
      rsp_rdata_d = rsp_rdata;
      rsp_err_d   = rsp_err;
      tmo_d       = tmo_q;
      case (state_q)
         S_IDLE: begin
            if (!empty) begin
               mem_valid_d = 1'b1;
               mem_addr_d  = fifo_addr[rd_ptr_q];
               mem_wdata_d = fifo_wdata[rd_ptr_q];
               mem_wstrb_d = fifo_wstrb[rd_ptr_q];
            end
         end
         S_REQ: tmo_d = TMO_W'(1);
         S_WAIT: begin
            if (mem_ready) begin
               mem_valid_d = 1'b0;
               rsp_valid_d = 1'b1;
               rsp_err_d   = 1'b0;
               rsp_rdata_d = is_read ? mem_rdata : '0;
            end else if (tmo_q == TMO_W'(TIMEOUT)) begin
               mem_valid_d = 1'b0;
               rsp_valid_d = 1'b1;
               rsp_err_d   = 1'b1;
               rsp_rdata_d = is_read ? ERR_RDATA : '0;
            end else begin
               tmo_d = tmo_q + TMO_W'(1);
            end
         end
         S_RESP: if (rsp_ready) rsp_valid_d = 1'b0;
         default: ;
      endcase
      busy_d = (state_d != S_IDLE) || (count_d != '0);
   end

   always_ff @(posedge clk) begin
      if (!rst_n) begin
         mem_valid <= 1'b0;
         mem_addr  <= '0;
         mem_wdata <= '0;
         mem_wstrb <= '0;
         rsp_valid <= 1'b0;
         rsp_rdata <= '0;
         rsp_err   <= 1'b0;
         busy      <= 1'b0;
         tmo_q     <= '0;
      end else begin
         mem_valid <= mem_valid_d;
         mem_addr  <= mem_addr_d;
         mem_wdata <= mem_wdata_d;
         mem_wstrb <= mem_wstrb_d;
         rsp_valid <= rsp_valid_d;
         rsp_rdata <= rsp_rdata_d;
         rsp_err   <= rsp_err_d;
         busy      <= busy_d;
         tmo_q     <= tmo_d;
      end
   end

endmodule

// File: tb/tb_mem_bus_initiator.sv
// Bench for mem_bus_initiator: directed vector table, multi-cycle corner sequences,
// and random traffic checked against an in-order transaction-level scoreboard.
module tb_mem_bus_initiator;

   localparam logic [31:0] ERR_RDATA = 32'hDEAD_BEEF;

   logic        clk = 1'b0;
   logic        rst_n;
   logic        cmd_valid, cmd_ready;
   logic [31:0] cmd_addr, cmd_wdata;
   logic [3:0]  cmd_wstrb;
   logic        rsp_valid, rsp_ready, rsp_err;
   logic [31:0] rsp_rdata;
   logic        mem_valid, mem_ready;
   logic [31:0] mem_addr, mem_wdata, mem_rdata;
   logic [3:0]  mem_wstrb;
   logic        busy;

   mem_bus_initiator #(.CMD_DEPTH(4), .TIMEOUT(16), .ERR_RDATA(ERR_RDATA)) dut (
      .clk(clk), .rst_n(rst_n),
      .cmd_valid(cmd_valid), .cmd_ready(cmd_ready), .cmd_addr(cmd_addr),
      .cmd_wdata(cmd_wdata), .cmd_wstrb(cmd_wstrb),
      .rsp_valid(rsp_valid), .rsp_ready(rsp_ready), .rsp_rdata(rsp_rdata), .rsp_err(rsp_err),
      .mem_valid(mem_valid), .mem_addr(mem_addr), .mem_wdata(mem_wdata), .mem_wstrb(mem_wstrb),
      .mem_rdata(mem_rdata), .mem_ready(mem_ready), .busy(busy)
   );

   always #5 clk = ~clk;

   typedef struct {
      logic [31:0] addr;
      logic [31:0] wdata;
      logic [3:0]  wstrb;
   } cmd_t;

   int checks = 0;
   int failures = 0;

   function automatic void check(input string name, input logic [31:0] act, input logic [31:0] exp);
      checks++;
      if (act !== exp) begin
         failures++;
         $display("FAIL %s actual=%h expected=%h time=%0t", name, act, exp, $time);
      end
   endfunction

   // Bench memory map: 0x100..0x1FF is 16 aliased registers, addr[7:6] selects latency
   function automatic bit is_mapped(input logic [31:0] a);
      return a[31:8] == 24'h000001;
   endfunction

   function automatic int resp_lat(input logic [31:0] a);
      return int'(a[7:6]) + 1;
   endfunction

   logic [31:0] r_mem [16];
   logic [31:0] m_mem [16];

   // Responder: ready registered from what it saw during the cycle; optional stale hold
   int   vcnt = 0, stale_left = 0, stale_hold = 0;
   bit   done_r = 0;
   logic nxt_ready;
   logic [31:0] nxt_rdata;
   always @(negedge clk) begin
      nxt_ready = 1'b0;
      nxt_rdata = $urandom;
      if (!rst_n) begin
         vcnt = 0; done_r = 0; stale_left = 0;
      end else begin
         if (mem_valid) begin
            vcnt++;
            if (!done_r && is_mapped(mem_addr) && vcnt == resp_lat(mem_addr)) begin
               done_r = 1; nxt_ready = 1'b1; stale_left = stale_hold;
               if (mem_wstrb == 4'b0000) nxt_rdata = r_mem[mem_addr[5:2]];
               else for (int b = 0; b < 4; b++)
                  if (mem_wstrb[b]) r_mem[mem_addr[5:2]][8*b +: 8] = mem_wdata[8*b +: 8];
            end
         end else begin
            vcnt = 0; done_r = 0;
         end
         if (!nxt_ready && stale_left > 0) begin
            nxt_ready = 1'b1; stale_left--;
         end
      end
      @(posedge clk);
      #1;
      mem_ready = nxt_ready;
      mem_rdata = nxt_rdata;
   end

   // Monitor + scoreboard: bus contents, inter-burst gap, response order/values/stability
   cmd_t bus_q[$], pend_q[$];
   cmd_t cur, c;
   int   burst_len = 0, last_burst = 0, gap = 0, nbursts = 0, min_gap = 1000;
   int   n_rsp = 0, stale_seen = 0;
   bit   prev_hold = 0;
   logic [31:0] prev_rdata, last_rsp_rdata, exp_rd;
   logic        prev_err, exp_err;
   always @(negedge clk) begin
      if (!rst_n) begin
         bus_q.delete(); pend_q.delete();
         burst_len = 0; gap = 0; nbursts = 0; prev_hold = 0;
      end else begin
         if (mem_valid) begin
            if (burst_len == 0) begin
               if (nbursts > 0 && gap < min_gap) min_gap = gap;
               if (mem_ready) stale_seen++;
               if (bus_q.size() == 0) begin
                  check("bus_unexpected", 32'(1), 32'(0));
                  cur = '{default: '0};
               end else cur = bus_q.pop_front();
            end
            burst_len++;
            check("mem_addr", mem_addr, cur.addr);
            check("mem_wdata", mem_wdata, cur.wdata);
            check("mem_wstrb", 32'(mem_wstrb), 32'(cur.wstrb));
         end else if (burst_len > 0) begin
            last_burst = burst_len; nbursts++; burst_len = 0; gap = 1;
         end else gap++;

         if (prev_hold) begin
            check("rsp_hold_valid", 32'(rsp_valid), 32'(1));
            check("rsp_hold_rdata", rsp_rdata, prev_rdata);
            check("rsp_hold_err", 32'(rsp_err), 32'(prev_err));
         end
         if (rsp_valid && rsp_ready) begin
            n_rsp++;
            last_rsp_rdata = rsp_rdata;
            if (pend_q.size() == 0) check("rsp_unexpected", 32'(1), 32'(0));
            else begin
               c = pend_q.pop_front();
               if (is_mapped(c.addr)) begin
                  exp_err = 1'b0;
                  exp_rd  = '0;
                  if (c.wstrb == 4'b0000) exp_rd = m_mem[c.addr[5:2]];
                  else for (int b = 0; b < 4; b++)
                     if (c.wstrb[b]) m_mem[c.addr[5:2]][8*b +: 8] = c.wdata[8*b +: 8];
               end else begin
                  exp_err = 1'b1;
                  exp_rd  = (c.wstrb == 4'b0000) ? ERR_RDATA : 32'h0;
               end
               check("rsp_rdata", rsp_rdata, exp_rd);
               check("rsp_err", 32'(rsp_err), 32'(exp_err));
            end
         end
         prev_hold  = rsp_valid && !rsp_ready;
         prev_rdata = rsp_rdata;
         prev_err   = rsp_err;

         if (cmd_valid && cmd_ready) begin
            bus_q.push_back('{cmd_addr, cmd_wdata, cmd_wstrb});
            pend_q.push_back('{cmd_addr, cmd_wdata, cmd_wstrb});
         end
      end
   end

   task automatic push(input logic [31:0] a, input logic [31:0] d, input logic [3:0] s);
      int n = 0;
      cmd_addr = a; cmd_wdata = d; cmd_wstrb = s; cmd_valid = 1'b1;
      while (!cmd_ready && n < 200) begin @(posedge clk); #1; n++; end
      if (n >= 200) check("push_timeout", 32'(0), 32'(1));
      @(posedge clk); #1;
      cmd_valid = 1'b0;
   endtask

   task automatic drain(input string name, input int bound);
      int n = 0;
      while ((pend_q.size() != 0 || busy) && n < bound) begin @(posedge clk); #1; n++; end
      check(name, 32'((pend_q.size() == 0 && !busy) ? 1 : 0), 32'(1));
   endtask

   typedef struct {
      logic [31:0] addr;
      logic [31:0] wdata;
      logic [3:0]  wstrb;
      logic [31:0] exp_rdata;
      logic        exp_err;
      int          exp_lat;
      int          exp_burst;
   } vec_t;

   vec_t vt [8];

   initial begin
      #200000;
      $display("FAIL watchdog expired at time %0t", $time);
      $fatal(1, "watchdog");
   end

   initial begin
      int lat, sent, cyc, n_before;
      bit hs;
      for (int i = 0; i < 16; i++) begin r_mem[i] = '0; m_mem[i] = '0; end
      rst_n = 1'b0; cmd_valid = 1'b0; cmd_addr = '0; cmd_wdata = '0; cmd_wstrb = '0;
      rsp_ready = 1'b1; mem_ready = 1'b0; mem_rdata = '0;

      vt[0] = '{32'h104,  32'h0000_00A5, 4'b0001, 32'h0,          1'b0, 3,  2};
      vt[1] = '{32'h104,  32'h0,         4'b0000, 32'h0000_00A5,  1'b0, 3,  2};
      vt[2] = '{32'h108,  32'h1122_3344, 4'b1010, 32'h0,          1'b0, 3,  2};
      vt[3] = '{32'h108,  32'h0,         4'b0000, 32'h1100_3300,  1'b0, 3,  2};
      vt[4] = '{32'h2000, 32'h0,         4'b0000, 32'hDEAD_BEEF,  1'b1, 18, 17};
      vt[5] = '{32'h2004, 32'h55,        4'b1111, 32'h0,          1'b1, 18, 17};
      vt[6] = '{32'h144,  32'hFFFF_0000, 4'b1100, 32'h0,          1'b0, 4,  3};
      vt[7] = '{32'h104,  32'h0,         4'b0000, 32'hFFFF_00A5,  1'b0, 3,  2};

      repeat (3) @(posedge clk);
      #1;
      check("rst_mem_valid", 32'(mem_valid), 32'(0));
      check("rst_mem_addr", mem_addr, 32'h0);
      check("rst_rsp_valid", 32'(rsp_valid), 32'(0));
      check("rst_rsp_rdata", rsp_rdata, 32'h0);
      check("rst_rsp_err", 32'(rsp_err), 32'(0));
      check("rst_busy", 32'(busy), 32'(0));
      rst_n = 1'b1;
      @(posedge clk); #1;
      check("rel_cmd_ready", 32'(cmd_ready), 32'(1));
      check("rel_busy", 32'(busy), 32'(0));
      check("rel_mem_valid", 32'(mem_valid), 32'(0));

      // Directed vectors, one command at a time
      for (int i = 0; i < 8; i++) begin
         cmd_addr = vt[i].addr; cmd_wdata = vt[i].wdata; cmd_wstrb = vt[i].wstrb;
         cmd_valid = 1'b1;
         check("vec_cmd_ready", 32'(cmd_ready), 32'(1));
         @(posedge clk); #1;
         cmd_valid = 1'b0;
         lat = 0;
         while (!rsp_valid && lat < 60) begin @(posedge clk); #1; lat++; end
         check("vec_latency", 32'(lat), 32'(vt[i].exp_lat));
         check("vec_rdata", rsp_rdata, vt[i].exp_rdata);
         check("vec_err", 32'(rsp_err), 32'(vt[i].exp_err));
         repeat (2) @(posedge clk);
         #1;
         check("vec_burst_len", 32'(last_burst), 32'(vt[i].exp_burst));
         check("vec_busy_idle", 32'(busy), 32'(0));
         if (i == 0) check("model_reg_a5", r_mem[1], 32'h0000_00A5);
      end

      // Backpressure: 4 queued + 1 in flight with no response accepted
      rsp_ready = 1'b0;
      for (int i = 0; i < 5; i++) begin
         check("bp_cmd_ready", 32'(cmd_ready), 32'(1));
         case (i)
            0: push(32'h110, 32'hCAFE_0000, 4'b1111);
            1: push(32'h110, 32'h0, 4'b0000);
            2: push(32'h114, 32'h1234_5678, 4'b0011);
            3: push(32'h114, 32'h0, 4'b0000);
            default: push(32'h3000, 32'h0, 4'b0000);
         endcase
      end
      check("bp_full", 32'(cmd_ready), 32'(0));
      check("bp_busy", 32'(busy), 32'(1));
      repeat (10) @(posedge clk);
      #1;
      check("bp_still_full", 32'(cmd_ready), 32'(0));
      check("bp_rsp_pending", 32'(rsp_valid), 32'(1));
      rsp_ready = 1'b1;
      drain("bp_drain", 500);

      // Timeout followed by a queued normal command
      push(32'h2008, 32'h0, 4'b0000);
      push(32'h104, 32'h0, 4'b0000);
      drain("tmo_drain", 200);
      check("tmo_next_burst", 32'(last_burst), 32'(2));

      // Stale ready held into the next REQ cycle
      stale_hold = 3;
      push(32'h104, 32'h77, 4'b0001);
      push(32'h184, 32'h0, 4'b0000);
      drain("stale_drain", 200);
      stale_hold = 0;
      check("stale_seen", 32'(stale_seen > 0 ? 1 : 0), 32'(1));
      check("stale_burst_len", 32'(last_burst), 32'(4));
      check("stale_rdata", last_rsp_rdata, 32'hFFFF_0077);

      // Reset while in WAIT with two commands queued
      push(32'h2010, 32'h0, 4'b0000);
      push(32'h104, 32'h99, 4'b0001);
      push(32'h108, 32'h0, 4'b0000);
      cyc = 0;
      while (!mem_valid && cyc < 50) begin @(posedge clk); #1; cyc++; end
      repeat (5) @(posedge clk);
      #1;
      n_before = n_rsp;
      rst_n = 1'b0;
      @(posedge clk); #1;
      check("mid_rst_mem_valid", 32'(mem_valid), 32'(0));
      check("mid_rst_rsp_valid", 32'(rsp_valid), 32'(0));
      check("mid_rst_busy", 32'(busy), 32'(0));
      check("mid_rst_cmd_ready", 32'(cmd_ready), 32'(1));
      rst_n = 1'b1;
      repeat (30) @(posedge clk);
      #1;
      check("mid_rst_no_rsp", 32'(n_rsp), 32'(n_before));
      check("mid_rst_no_bus", 32'(nbursts), 32'(0));
      check("mid_rst_reg_kept", r_mem[1], 32'hFFFF_0077);

      // Random traffic against the scoreboard
      sent = 0; cyc = 0; cmd_valid = 1'b0;
      while (sent < 60 && cyc < 20000) begin
         if (!cmd_valid && $urandom_range(0, 3) != 0) begin
            if ($urandom_range(0, 7) == 0) cmd_addr = 32'h0000_4000 | ($urandom & 32'hFC);
            else                           cmd_addr = 32'h0000_0100 | ($urandom & 32'hFC);
            cmd_wdata = $urandom;
            cmd_wstrb = ($urandom_range(0, 3) == 0) ? 4'b0000 : 4'($urandom);
            cmd_valid = 1'b1;
         end
         rsp_ready  = ($urandom_range(0, 2) != 0);
         stale_hold = $urandom_range(0, 3);
         hs = cmd_valid && cmd_ready;
         @(posedge clk); #1;
         cyc++;
         if (hs) begin sent++; cmd_valid = 1'b0; end
      end
      cmd_valid = 1'b0;
      check("rand_sent", 32'(sent), 32'(60));
      rsp_ready = 1'b1;
      drain("rand_drain", 3000);
      check("min_gap_ge2", 32'(min_gap >= 2 ? 1 : 0), 32'(1));
      check("final_cmd_ready", 32'(cmd_ready), 32'(1));

      $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
      $finish;
   end

endmodule
